// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive controller: frame geometry, start/stop
// bit levels and the legacy-compatible FSM state encoding.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// Byte delivery interface from the PS/2 receiver to the keyboard decode logic:
// valid/ready byte handshake plus the one-cycle status pulses.
interface ps2_rx_ctrl_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     frame_err;
    logic                     overrun;
    logic                     parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, parity_err,
        output rx_ready
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// Pin synchronisers for ps2_clk/ps2_data, ps2_clk deglitch filter and the
// registered falling-edge pulse (fe) with the data bit sampled alongside it.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fe,
    output logic rx_bit
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_filt;
    logic [CW-1:0]          cnt;

    // Idle PS/2 lines are high, so the chains come out of reset at 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_filt <= 1'b1;
            cnt      <= '0;
            fe       <= 1'b0;
            rx_bit   <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync[SYNC_STAGES-1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= ~clk_filt;
                cnt      <= '0;
                fe       <= clk_filt;
                if (clk_filt) begin
                    rx_bit <= data_sync[SYNC_STAGES-1];
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive sequencer: drives the external 11-bit shift register, checks the
// frame and hands bytes out over valid/ready. Define PS2_RX_PARITY_CHK_EN to check odd parity.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    output logic                      sr_load,
    output logic [PS2_FRAME_BITS-1:0] sr_data,
    output logic                      sr_shren,
    output logic                      sr_din,
    input  logic [PS2_DATA_BITS-1:0]  sr_dout,
    ps2_rx_ctrl_if.master             rx
);

    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic                     fe;
    logic                     rx_bit;
    logic [1:0]               state;
    logic [3:0]               bit_cnt;
    logic [TW-1:0]            timer;
    logic                     stop_bit;
    logic                     par_ok;
    logic                     start_edge;
    logic                     tmo;
    logic                     in_check;
    logic                     good;
    logic                     commit;
    logic [PS2_DATA_BITS-1:0] rx_data_q;
    logic                     rx_valid_q;
    logic                     frame_err_q;
    logic                     overrun_q;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fe       (fe),
        .rx_bit   (rx_bit)
    );

    // The start bit enters as the cleared value, so only bits 1..10 are shifted.
    assign start_edge = (state == ST_IDLE) && fe && (rx_bit == PS2_START_BIT);
    assign tmo        = (state == ST_RECV) && !fe && (timer == TW'(TIMEOUT_CYC - 1));
    assign in_check   = (state == ST_CHECK);
    assign good       = (stop_bit == PS2_STOP_BIT) && par_ok;
    assign commit     = in_check && good && (!rx_valid_q || rx.rx_ready);

    assign sr_load  = start_edge;
    assign sr_data  = '0;
    assign sr_shren = (state == ST_RECV) && fe;
    assign sr_din   = sr_shren && rx_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            timer    <= '0;
            stop_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (start_edge) begin
                        bit_cnt <= 4'd1;
                        state   <= ST_RECV;
                    end else begin
                        bit_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    // An edge landing on the timeout cycle wins over the abort.
                    if (fe) begin
                        timer   <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            stop_bit <= rx_bit;
                            state    <= ST_CHECK;
                        end
                    end else if (tmo) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CHECK: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef PS2_RX_PARITY_CHK_EN
    logic par_acc;
    logic parity_err_q;

    // Odd parity: D0..D7 plus the parity bit must XOR to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc <= 1'b0;
        end else if (start_edge) begin
            par_acc <= 1'b0;
        end else if (sr_shren && (bit_cnt < LAST_BIT)) begin
            par_acc <= par_acc ^ rx_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= in_check && (stop_bit == PS2_STOP_BIT) && !par_acc;
        end
    end

    assign par_ok        = par_acc;
    assign rx.parity_err = parity_err_q;
`else
    assign par_ok        = 1'b1;
    assign rx.parity_err = 1'b0;
`endif

    // A byte committed in the same cycle as a handshake keeps rx_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= tmo || (in_check && (stop_bit != PS2_STOP_BIT));
            overrun_q   <= in_check && good && rx_valid_q && !rx.rx_ready;
            if (commit) begin
                rx_data_q  <= sr_dout;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = rx_data_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;

endmodule
